// File: rtl/stream_mux4to1.sv
// stream_mux4to1: merges four valid/ready packet streams onto one output.
// Round-robin arbitration that stays with a channel until its last beat,
// followed by a single registered output stage (1 cycle latency, 1 beat/cycle).
//
// Handshake: a beat moves on any rising edge where valid && ready are both
// high on the same channel; valid/data/last must stay stable until that
// happens, and ready may depend on valid but never the other way round.
module stream_mux4to1 #(
    parameter int DW = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [3:0]      in_valid_i,
    input  logic [4*DW-1:0] in_data_i,
    input  logic [3:0]      in_last_i,
    output logic [3:0]      in_ready_o,
    output logic            out_valid_o,
    output logic [DW-1:0]   out_data_o,
    output logic            out_last_o,
    output logic [1:0]      out_sel_o,
    input  logic            out_ready_i,
    output logic            dbg_state_o,
    output logic [1:0]      dbg_ptr_o
);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    lock_ch_q, lock_ch_d;

    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic          out_last_q;
    logic [1:0]    out_sel_q;

    logic [1:0]    cand;
    logic          cand_found;
    logic          load_en;
    logic          accept;
    logic [DW-1:0] cand_data;
    logic          cand_last;

    // The output register may take a new beat when it is empty or draining.
    assign load_en = !out_valid_q || out_ready_i;

    // Pick the candidate channel: the locked one, or the first valid from ptr.
    always_comb begin
        cand       = ptr_q;
        cand_found = 1'b0;
        if (state_q == LOCK) begin
            cand       = lock_ch_q;
            cand_found = 1'b1;
        end else begin
            // Walk from the farthest offset down so the nearest valid wins.
            for (int k = 3; k >= 0; k--) begin
                if (in_valid_i[ptr_q + 2'(k)]) begin
                    cand       = ptr_q + 2'(k);
                    cand_found = 1'b1;
                end
            end
        end
    end

    // FSM output logic: one-hot ready towards the candidate only.
    always_comb begin
        in_ready_o = 4'b0000;
        if (!rst_i && cand_found && load_en) begin
            in_ready_o[cand] = 1'b1;
        end
    end

    assign accept    = |(in_valid_i & in_ready_o);
    assign cand_data = in_data_i[32'(cand)*DW +: DW];
    assign cand_last = in_last_i[cand];

    // FSM next-state logic: lock on a non-last beat, release and rotate on last.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lock_ch_d = lock_ch_q;
        case (state_q)
            ARB: begin
                if (accept) begin
                    if (cand_last) begin
                        ptr_d = cand + 2'd1;
                    end else begin
                        state_d   = LOCK;
                        lock_ch_d = cand;
                    end
                end
            end
            LOCK: begin
                if (accept && cand_last) begin
                    state_d = ARB;
                    ptr_d   = lock_ch_q + 2'd1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB;
            ptr_q     <= 2'd0;
            lock_ch_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    // Output stage: capture the accepted beat, hold it while downstream stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= 2'd0;
        end else if (load_en) begin
            out_valid_q <= accept;
            if (accept) begin
                out_data_q <= cand_data;
                out_last_q <= cand_last;
                out_sel_q  <= cand;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_sel_o   = out_sel_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_stream_mux4to1.sv
// Testbench for stream_mux4to1: per-channel source queues drive the inputs,
// a spec-level model predicts in_ready, and accepted beats go to an expected
// queue that is checked against every output handshake.
module tb_stream_mux4to1;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      in_valid;
    logic [4*DW-1:0] in_data;
    logic [3:0]      in_last;
    logic [3:0]      in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [1:0]      out_sel;
    logic            out_ready;
    logic            dbg_state;
    logic [1:0]      dbg_ptr;

    always #5 clk = ~clk;

    stream_mux4to1 #(.DW(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_sel_o   (out_sel),
        .out_ready_i (out_ready),
        .dbg_state_o (dbg_state),
        .dbg_ptr_o   (dbg_ptr)
    );

    // sources: {last, data}; scoreboard entries: {sel, last, data}
    logic [DW:0]   src_q [4][$];
    logic [3:0]    src_off;
    logic [DW+2:0] exp_q [$];
    int            sel_log [$];
    int            cyc_log [$];
    int            exp_sel [$];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;

    // spec model state
    logic          m_ov;
    logic          m_lock;
    logic [1:0]    m_ptr;
    logic [1:0]    m_lock_ch;
    logic          stall_prev;
    logic [DW+2:0] snap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        logic [DW:0] b;
        for (int c = 0; c < 4; c++) begin
            if (src_q[c].size() > 0 && !src_off[c]) begin
                b = src_q[c][0];
                in_valid[c]            = 1'b1;
                in_data[c*DW +: DW]    = b[DW-1:0];
                in_last[c]             = b[DW];
            end else begin
                in_valid[c]            = 1'b0;
                in_data[c*DW +: DW]    = '0;
                in_last[c]             = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive, check at mid-cycle, advance the model, wait for next negedge.
    task automatic step();
        logic [3:0]    exp_rdy;
        logic          le;
        logic          acc;
        logic          found;
        logic [DW:0]   b;
        logic [DW+2:0] e;
        int            c2;
        drive();
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        if (stall_prev) check("stall_hold", {21'd0, out_sel, out_last, out_data}, {21'd0, snap});
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_beat", {21'd0, out_sel, out_last, out_data}, {21'd0, e});
            end
            sel_log.push_back(int'(out_sel));
            cyc_log.push_back(cyc);
        end
        exp_rdy = 4'b0000;
        le      = !m_ov || out_ready;
        if (!rst) begin
            if (m_lock) begin
                exp_rdy[m_lock_ch] = le;
            end else begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    c2 = (int'(m_ptr) + k) % 4;
                    if (!found && in_valid[c2]) begin
                        found       = 1'b1;
                        exp_rdy[c2] = le;
                    end
                end
            end
        end
        check("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
        acc = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (in_valid[c] && exp_rdy[c]) begin
                acc = 1'b1;
                b   = src_q[c].pop_front();
                exp_q.push_back({2'(c), b});
                if (b[DW]) begin
                    m_lock = 1'b0;
                    m_ptr  = 2'(c + 1);
                end else begin
                    m_lock    = 1'b1;
                    m_lock_ch = 2'(c);
                end
            end
        end
        stall_prev = out_valid && !out_ready && !rst;
        snap       = {out_sel, out_last, out_data};
        if (rst) begin
            m_ov   = 1'b0;
            m_lock = 1'b0;
            m_ptr  = 2'd0;
            exp_q.delete();
        end else if (le) begin
            m_ov = acc;
        end
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic busy();
        logic any = 1'b0;
        for (int c = 0; c < 4; c++) if (src_q[c].size() > 0) any = 1'b1;
        return any || (exp_q.size() != 0) || m_ov;
    endfunction

    task automatic drain(input int max_cyc);
        int n = 0;
        while (busy() && n < max_cyc) begin
            step();
            n++;
        end
        if (busy()) check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, sel_log.size(), exp_sel.size());
        for (int i = 0; i < exp_sel.size() && i < sel_log.size(); i++) begin
            check({tag, "_sel"}, sel_log[i], exp_sel[i]);
        end
        sel_log.delete();
        cyc_log.delete();
    endtask

    task automatic push_pkt(input int c, input int len, input logic [DW-1:0] base);
        for (int i = 0; i < len; i++) begin
            src_q[c].push_back({(i == len - 1), base + DW'(i)});
        end
    endtask

    initial begin
        rst        = 1'b1;
        out_ready  = 1'b0;
        src_off    = 4'b0000;
        in_valid   = '0;
        in_data    = '0;
        in_last    = '0;
        stall_prev = 1'b0;
        snap       = '0;
        m_ov       = 1'b0;
        m_lock     = 1'b0;
        m_ptr      = 2'd0;
        m_lock_ch  = 2'd0;
        @(posedge clk);
        @(negedge clk);

        // Reset/idle with every channel valid, then round-robin single beats.
        src_q[0].push_back({1'b1, 8'hA0});
        src_q[1].push_back({1'b1, 8'hB1});
        src_q[2].push_back({1'b1, 8'hC2});
        src_q[3].push_back({1'b1, 8'hD3});
        src_q[0].push_back({1'b1, 8'hA4});
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_in_ready", {28'd0, in_ready}, 32'd0);
            check("rst_out", {23'd0, out_valid, out_data}, 32'd0);
            check("rst_sel", {30'd0, out_sel}, 32'd0);
        end
        rst = 1'b0;
        drain(40);
        for (int i = 1; i < cyc_log.size(); i++) check("rr_b2b", cyc_log[i] - cyc_log[i-1], 1);
        exp_sel = '{0, 1, 2, 3, 0};
        check_log("rr");

        // Packet lock on ch2 while ch0/ch1 wait; ch3 idle so ptr=3 wraps to ch0.
        push_pkt(2, 3, 8'h20);
        step();
        push_pkt(0, 1, 8'h05);
        push_pkt(1, 1, 8'h15);
        drain(40);
        exp_sel = '{2, 2, 2, 0, 1};
        check_log("lock");

        // Backpressure mid-packet on ch3.
        push_pkt(3, 4, 8'h30);
        step();
        step();
        out_ready = 1'b0;
        push_pkt(0, 1, 8'h07);
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b1;
        drain(40);
        exp_sel = '{3, 3, 3, 3, 0};
        check_log("bp");

        // Source bubble in LOCK: ch1 drops valid, ch3 must wait.
        push_pkt(1, 3, 8'h40);
        push_pkt(3, 1, 8'h50);
        step();
        src_off[1] = 1'b1;
        step();
        check("bubble_state", {31'd0, dbg_state}, 32'd1);
        step();
        check("bubble_gap_valid", {31'd0, out_valid}, 32'd0);
        src_off[1] = 1'b0;
        drain(40);
        exp_sel = '{1, 1, 1, 3};
        check_log("bubble");

        // Random packets, random source gaps and random backpressure.
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (src_q[c].size() == 0 && $urandom_range(0, 3) == 0)
                    push_pkt(c, $urandom_range(1, 4), DW'($urandom_range(0, 255)));
                src_off[c] = ($urandom_range(0, 7) == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        src_off   = 4'b0000;
        out_ready = 1'b1;
        drain(200);
        sel_log.delete();
        cyc_log.delete();

        // Reset mid-packet on ch0 while ch1 is pending.
        rst = 1'b1;
        step();
        rst = 1'b0;
        push_pkt(0, 5, 8'h60);
        step();
        step();
        check("mid_pre_valid", {31'd0, out_valid}, 32'd1);
        push_pkt(1, 1, 8'h70);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_post_valid", {31'd0, out_valid}, 32'd0);
        check("mid_post_state", {31'd0, dbg_state}, 32'd0);
        check("mid_post_ptr", {30'd0, dbg_ptr}, 32'd0);
        src_q[0].delete();
        sel_log.delete();
        cyc_log.delete();
        drain(40);
        exp_sel = '{1};
        check_log("mid_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_mux4to1.md
Name: stream_mux4to1

Overview:
- 4-to-1 packet stream multiplexer: merges four valid/ready input channels onto one output channel. It is the combining counterpart of the team's 1-to-4 demux.
- Round-robin arbitration between channels, held on a packet boundary: a granted channel keeps the output until its `last` beat.
- Single registered output stage. Latency 1 cycle, full throughput of 1 beat/cycle.
- Sits upstream of a shared sink, for example a single UART TX or memory-write port fed by four sources.

Parameters:
- DW, 8, data width per channel in bits.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  4  per-channel beat valid; bit i belongs to channel i.
- in_data  input  4*DW  channel i occupies in_data[i*DW +: DW].
- in_last  input  4  per-channel end-of-packet flag; qualified by in_valid.
- in_ready  output  4  per-channel accept; at most one bit high in any cycle.
- out_valid  output  1  output beat valid (registered).
- out_data  output  DW  output beat data (registered).
- out_last  output  1  output end-of-packet (registered).
- out_sel  output  2  index of the source channel of the current output beat (registered).
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_last=0, out_sel=0, round-robin pointer ptr=0, state=ARB.
  - While rst=1, in_ready=4'b0000 combinationally.
  - Reset mid-packet drops the lock and any held output beat with no further output.
- Load enable: load_en = !out_valid || out_ready. The output register captures a new beat only when load_en=1.
  - If load_en=1 and no beat is accepted, out_valid goes to 0 at the next edge.
  - If out_valid=1 and out_ready=0, out_data/out_last/out_sel hold stable and in_ready=0.
- State ARB (no packet in progress):
  - Candidate g = first channel with in_valid=1, searched in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - in_ready[g] = load_en; all other in_ready bits are 0.
  - On accept (in_valid[g] && in_ready[g]): register data, last and sel=g.
  - If in_last[g]=1: stay in ARB and set ptr = g+1 mod 4 (3 wraps to 0).
  - If in_last[g]=0: go to LOCK with lock_ch=g; ptr is unchanged.
- State LOCK:
  - Only lock_ch is eligible: in_ready[lock_ch] = load_en; other channels get in_ready=0 even when they are valid.
  - On accept with in_last=1: go to ARB and set ptr = lock_ch+1 mod 4.
  - If lock_ch drops in_valid mid-packet: remain in LOCK and emit no beats (bubbles allowed); do not arbitrate.
- in_ready is combinational from state, ptr, in_valid, rst and load_en (out_valid, out_ready). There is no combinational path from in_data to any output.
- Throughput: back-to-back beats at 1/cycle while out_ready=1. An output stall propagates to in_ready in the same cycle.
- One-hot rule: in_ready is never multi-hot; an accept always targets exactly the channel named by out_sel on the next cycle.
- Ordering: beats of one packet appear contiguously and in order. Packets from different channels never interleave.

Test Plan:
- Reset/idle: hold rst=1 for 3 cycles with all in_valid=1 → in_ready=0000, out_valid=0, out_data=0 throughout; after release, first grant goes to ch0 (ptr=0).
- Round-robin single beats: all 4 channels valid with last=1, data A0/B1/C2/D3, out_ready=1 → output sel sequence 0,1,2,3,0 on consecutive cycles, data matches per channel, 1-cycle latency.
- Packet lock: ch2 sends a 3-beat packet (last on beat 3) while ch0 and ch1 hold valid → out_sel=2 for 3 contiguous beats, then ch3 if valid, else ch0 (ptr=3 wraps).
- Backpressure: out_ready=0 for 4 cycles mid-packet → out_data/out_last/out_sel stable, in_ready=0000; on out_ready=1 the stream resumes with no lost or duplicated beat.
- Source bubble in LOCK: ch1 drops valid for 2 cycles mid-packet while ch3 is valid → no ch3 beats appear; out_valid=0 during the gap; ch1 packet completes before ch3 is granted.
- Reset mid-packet: assert rst during a ch0 packet with out_valid=1 → next cycle out_valid=0, state ARB, ptr=0; after release, a pending ch1 can win if ch0 is idle.
